hazard_unit_mc: RTL

Parametrised pipeline hazard controller for the 5-stage RV32I core. It extends the existing forwarding and stall logic with:
- an N-operand forwarding network with x0 suppression;
- a scoreboard for a fixed-latency multi-cycle unit (MUL/DIV);
- a memory-wait FSM with a stall counter and timeout flag;
- a latched redirect, so a branch taken during a memory stall is not lost.

It sits beside the pipeline registers and drives their enables and flushes.

---
 rtl/hazard_pkg.sv | 5 +
 rtl/mc_scoreboard.sv | 43 ++++
 rtl/hazard_unit_mc.sv | 97 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_M = 2'b01, FWD_W = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, WAIT, TIMEOUT} mwait_state_t;
endpackage

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: single-entry busy tracker for the fixed-latency multi-cycle unit
// In:  issue_i loads rd_i; src_i/src_vld_i are D operands; mc_op_d_i/mc_op_e_i flag MUL/DIV in D/E.
// Out: sb_hit_o when a D operand reads the busy destination; mc_struct_o when D's MUL/DIV must wait.
module mc_scoreboard #(
  parameter int RA_W   = 6,
  parameter int N_SRC  = 3,
  parameter int MC_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_i,
  input  logic [RA_W-1:0]         rd_i,
  input  logic [N_SRC*RA_W-1:0]   src_i,
  input  logic [N_SRC-1:0]        src_vld_i,
  input  logic                    mc_op_d_i,
  input  logic                    mc_op_e_i,
  output logic                    sb_hit_o,
  output logic                    mc_struct_o
);
  localparam int BW = $clog2(MC_LAT);
  localparam logic [BW-1:0] LOAD = BW'(MC_LAT - 1);
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [RA_W-1:0] busy_rd_q, busy_rd_d;
  logic busy, hit;
  assign busy = busy_cnt_q != '0;
  always_comb begin
    busy_cnt_d = issue_i ? LOAD : busy ? busy_cnt_q - BW'(1) : busy_cnt_q;
    busy_rd_d = issue_i ? rd_i : busy_rd_q;
    hit = 1'b0;
    for (int i = 0; i < N_SRC; i++) hit |= src_vld_i[i] & (src_i[i*RA_W +: RA_W] == busy_rd_q);
  end
  assign sb_hit_o = busy & hit;
  assign mc_struct_o = mc_op_d_i & (busy | mc_op_e_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= '0;
      busy_rd_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      busy_rd_q <= busy_rd_d;
    end
  end
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, stall, flush and memory-wait control for the 5-stage pipeline
// In:  D/E source operands, E/M/W destinations, load/MUL-DIV/redirect flags, memory handshake.
// Out: per-operand forward selects, stage enables, D/E flushes, wait counter and timeout flag.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int RA_W        = 6,
  parameter int N_SRC       = 3,
  parameter int MC_LAT      = 4,
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC*RA_W-1:0]   src_D,
  input  logic [N_SRC*RA_W-1:0]   src_E,
  input  logic [N_SRC-1:0]        src_vld_D,
  input  logic [N_SRC-1:0]        src_vld_E,
  input  logic [RA_W-1:0]         rd_E,
  input  logic [RA_W-1:0]         rd_M,
  input  logic [RA_W-1:0]         rd_W,
  input  logic                    reg_write_E,
  input  logic                    reg_write_M,
  input  logic                    reg_write_W,
  input  logic                    mem_to_reg_E,
  input  logic                    mc_op_D,
  input  logic                    mc_op_E,
  input  logic                    pc_redirect_E,
  input  logic                    mem_transaction,
  input  logic                    data_ready,
  input  logic                    instruction_ready,
  output logic [2*N_SRC-1:0]      fwd_sel_E,
  output logic                    enable_F,
  output logic                    enable_D,
  output logic                    enable_E,
  output logic                    enable_M,
  output logic                    enable_W,
  output logic                    flush_D,
  output logic                    flush_E,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    mem_timeout
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
  mwait_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N_SRC-1:0] fwd;
  logic mem_wait, load_use, sb_hit, mc_struct, stall_D, issue, redir_pend_q, redir_pend_d, redirect_go;
  assign mem_wait = (mem_transaction & !data_ready) | !instruction_ready;
  always_comb begin
    fwd = '0;
    load_use = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      fwd[2*i +: 2] = (src_vld_E[i] & reg_write_M & (src_E[i*RA_W +: RA_W] == rd_M) & (rd_M != '0)) ? FWD_M :
                      (src_vld_E[i] & reg_write_W & (src_E[i*RA_W +: RA_W] == rd_W) & (rd_W != '0)) ? FWD_W : FWD_RF;
      load_use |= src_vld_D[i] & (src_D[i*RA_W +: RA_W] == rd_E);
    end
    load_use &= mem_to_reg_E & reg_write_E & (rd_E != '0);
  end
  assign issue = mc_op_E & !mem_wait & reg_write_E & (rd_E != '0);
  mc_scoreboard #(.RA_W(RA_W), .N_SRC(N_SRC), .MC_LAT(MC_LAT)) u_sb (
    .clk(clk), .rst_n(rst_n), .issue_i(issue), .rd_i(rd_E), .src_i(src_D), .src_vld_i(src_vld_D),
    .mc_op_d_i(mc_op_D), .mc_op_e_i(mc_op_E), .sb_hit_o(sb_hit), .mc_struct_o(mc_struct)
  );
  assign stall_D = load_use | sb_hit | mc_struct;
  // A redirect seen while memory stalls is held until the pipe moves again.
  assign redir_pend_d = mem_wait & (redir_pend_q | pc_redirect_E);
  assign redirect_go = !mem_wait & (pc_redirect_E | redir_pend_q);
  assign enable_E = rst_n & !mem_wait;
  assign enable_M = enable_E;
  assign enable_W = enable_E;
  assign enable_D = rst_n & !mem_wait & !stall_D;
  assign enable_F = rst_n & ((!mem_wait & !stall_D) | (mem_wait & pc_redirect_E));
  assign flush_D = !rst_n | redirect_go;
  assign flush_E = !rst_n | redirect_go | (stall_D & !mem_wait);
  assign fwd_sel_E = rst_n ? fwd : '0;
  assign stall_cnt = cnt_q;
  assign mem_timeout = rst_n & (state_q == TIMEOUT);
  // Counter value seen in a wait state is the number of wait-state cycles so far, so the
  // timeout is entered on the same edge the counter reaches the limit.
  always_comb begin
    cnt_d = mem_wait ? ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1)) : '0;
    state_d = !mem_wait ? RUN :
              (state_q == RUN) ? WAIT :
              (state_q == TIMEOUT || cnt_d >= LIMIT) ? TIMEOUT : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end
endmodule
